// File: rtl/riscv_mc_seq.sv
// rtl/riscv_mc_seq.sv - multi-cycle fetch/execute sequencer for a single-cycle RISC-V datapath
//
// Owns the PC and instruction register and runs one instruction at a time
// against variable-latency instruction and data memories. The PC and the
// register-file write enable are gated so that architectural state changes
// exactly once per instruction, in the RETIRE cycle.
//
// Optional build macro: RISCV_MC_SEQ_PERF_CNT_EN adds cycle, instret and stall counters.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/addr/rdata/rvalid     instruction fetch transaction (req is a one-cycle pulse)
//   dmem_req/we/addr/wdata/rdata/rvalid  data transaction (req is a one-cycle pulse)
//   alu_out, rs2_data, pc_next     datapath results consumed by the sequencer
//   ctl_mem_rd/wr, ctl_regwen      control-unit decode of the latched instruction
//   pc, instr, ld_data             architectural PC, instruction register, load-data register
//   rf_we, retire                  gated register write enable, one pulse per instruction
//   halted, bus_err                sticky terminal status (EBREAK / timeout or misaligned fetch)
//   cyc_cnt, instret_cnt, stall_cnt  performance counters (RISCV_MC_SEQ_PERF_CNT_EN only)
module riscv_mc_seq #(
    parameter int unsigned        XLEN     = 32,
    parameter logic [XLEN-1:0]    RESET_PC = '0,
    parameter int unsigned        MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc_next,
    input  logic            ctl_mem_rd,
    input  logic            ctl_mem_wr,
    input  logic            ctl_regwen,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic            retire,
    output logic            halted,
    output logic            bus_err
`ifdef RISCV_MC_SEQ_PERF_CNT_EN
    ,
    output logic [63:0]     cyc_cnt,
    output logic [63:0]     instret_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned   WW         = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
    localparam logic [31:0]   INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0]   INSTR_EBRK = 32'h0010_0073;

    localparam logic [2:0] S_IFETCH = 3'd0;
    localparam logic [2:0] S_IWAIT  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_DWAIT  = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic [2:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_inc;
    logic          d_is_load;   // captured in EXEC so DWAIT need not re-decode
    logic          mem_access;
    logic          pc_aligned;

    assign wait_inc   = wait_cnt + WW'(1);
    assign mem_access = ctl_mem_rd | ctl_mem_wr;
    assign pc_aligned = (pc[1:0] == 2'b00);

    // Request/strobe outputs are decoded from state; rst masks them so every
    // single-bit output reads 0 while reset is held.
    assign imem_req   = ~rst & (state == S_IFETCH) & pc_aligned;
    assign imem_addr  = pc;
    assign dmem_req   = ~rst & (state == S_EXEC) & mem_access;
    assign dmem_we    = dmem_req & ctl_mem_wr;   // store wins if both are decoded
    assign dmem_addr  = dmem_req ? alu_out  : '0;
    assign dmem_wdata = dmem_req ? rs2_data : '0;
    assign retire     = ~rst & (state == S_RETIRE);
    assign rf_we      = retire & ctl_regwen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IFETCH;
            pc        <= RESET_PC;
            instr     <= INSTR_NOP;
            ld_data   <= '0;
            halted    <= 1'b0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
            d_is_load <= 1'b0;
        end else begin
            case (state)
                S_IFETCH: begin
                    if (!pc_aligned) begin
                        bus_err <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_IWAIT;
                    end
                end
                S_IWAIT: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        if (imem_rdata == INSTR_EBRK) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIMIT) begin
                            bus_err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
                S_EXEC: begin
                    if (mem_access) begin
                        d_is_load <= ~ctl_mem_wr;
                        wait_cnt  <= '0;
                        state     <= S_DWAIT;
                    end else begin
                        state <= S_RETIRE;
                    end
                end
                S_DWAIT: begin
                    if (dmem_rvalid) begin
                        if (d_is_load) begin
                            ld_data <= dmem_rdata;
                        end
                        state <= S_RETIRE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIMIT) begin
                            bus_err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
                S_RETIRE: begin
                    pc    <= pc_next;
                    state <= S_IFETCH;
                end
                S_HALT: state <= S_HALT;
                S_ERR:  state <= S_ERR;
                default: begin
                    // Unused encoding: park in the error state rather than run.
                    bus_err <= 1'b1;
                    state   <= S_ERR;
                end
            endcase
        end
    end

`ifdef RISCV_MC_SEQ_PERF_CNT_EN
    logic running;
    logic stalled;

    assign running = (state != S_HALT) && (state != S_ERR);
    assign stalled = ((state == S_IWAIT) && !imem_rvalid) ||
                     ((state == S_DWAIT) && !dmem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            instret_cnt <= '0;
            stall_cnt   <= '0;
        end else if (running) begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (state == S_RETIRE) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
            if (stalled) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_mc_seq.sv
// tb/tb_riscv_mc_seq.sv - directed self-checking bench for riscv_mc_seq
module tb_riscv_mc_seq;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [31:0] pc_next;
    logic        ctl_mem_rd;
    logic        ctl_mem_wr;
    logic        ctl_regwen;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ld_data;
    logic        rf_we;
    logic        retire;
    logic        halted;
    logic        bus_err;
`ifdef RISCV_MC_SEQ_PERF_CNT_EN
    logic [63:0] cyc_cnt;
    logic [63:0] instret_cnt;
    logic [31:0] stall_cnt;
`endif

    riscv_mc_seq #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .alu_out     (alu_out),
        .rs2_data    (rs2_data),
        .pc_next     (pc_next),
        .ctl_mem_rd  (ctl_mem_rd),
        .ctl_mem_wr  (ctl_mem_wr),
        .ctl_regwen  (ctl_regwen),
        .pc          (pc),
        .instr       (instr),
        .ld_data     (ld_data),
        .rf_we       (rf_we),
        .retire      (retire),
        .halted      (halted),
        .bus_err     (bus_err)
`ifdef RISCV_MC_SEQ_PERF_CNT_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .instret_cnt (instret_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observations collected by run_instr (cycle 1 = the IFETCH cycle).
    int          n_imem_req, n_dmem_req, n_retire, n_rfwe;
    int          retire_cyc, rfwe_cyc, err_cyc;
    logic [31:0] cap_iaddr, cap_daddr, cap_wdata;
    logic        cap_we;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_rdata  = '0;
        imem_rvalid = 1'b0;
        dmem_rdata  = '0;
        dmem_rvalid = 1'b0;
        alu_out     = '0;
        rs2_data    = '0;
        pc_next     = '0;
        ctl_mem_rd  = 1'b0;
        ctl_mem_wr  = 1'b0;
        ctl_regwen  = 1'b0;
        tick();
        tick();
    endtask

    // Drives one instruction through the sequencer, acting as both memories.
    // ilat/dlat: response latency in cycles after the request (0 = never).
    // Stops right after the retire edge, or after max_cyc cycles.
    task automatic run_instr(input logic [31:0] iword, input int ilat,
                             input logic rd, input logic wr, input logic regwen,
                             input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [31:0] pcn, input logic [31:0] rdata,
                             input int dlat, input int max_cyc);
        int  icd;
        int  dcd;
        bit  done;
        icd = 0; dcd = 0; done = 0;
        n_imem_req = 0; n_dmem_req = 0; n_retire = 0; n_rfwe = 0;
        retire_cyc = 0; rfwe_cyc = 0; err_cyc = 0;
        cap_iaddr = 'x; cap_daddr = 'x; cap_wdata = 'x; cap_we = 1'bx;
        ctl_mem_rd = rd; ctl_mem_wr = wr; ctl_regwen = regwen;
        alu_out = alu; rs2_data = rs2; pc_next = pcn;
        imem_rdata = iword; dmem_rdata = rdata;
        for (int c = 1; c <= max_cyc; c++) begin
            imem_rvalid = (icd == 1);
            dmem_rvalid = (dcd == 1);
            if (icd > 0) icd--;
            if (dcd > 0) dcd--;
            #1;
            if (imem_req) begin n_imem_req++; icd = ilat; cap_iaddr = imem_addr; end
            if (dmem_req) begin
                n_dmem_req++; dcd = dlat;
                cap_daddr = dmem_addr; cap_wdata = dmem_wdata; cap_we = dmem_we;
            end
            if (retire) begin n_retire++; retire_cyc = c; done = 1; end
            if (rf_we) begin n_rfwe++; rfwe_cyc = c; end
            if (bus_err && err_cyc == 0) err_cyc = c;
            tick();
            if (done) break;
        end
        imem_rvalid = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pc !== RST_PC) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
        tests++; if (instr !== 32'h0000_0013) begin fails++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        tests++; if (ld_data !== 32'h0) begin fails++; $display("FAIL reset_ld_data: got %h expected 0", ld_data); end
        tests++; if ({imem_req, dmem_req, dmem_we, rf_we, retire, halted, bus_err} !== 7'b0) begin
            fails++; $display("FAIL reset_bits: got %b expected 0000000", {imem_req, dmem_req, dmem_we, rf_we, retire, halted, bus_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        run_instr(32'h0050_0093, 1, 1'b0, 1'b0, 1'b1, 32'h5, 32'h0, 32'h4, 32'h0, 1, 12);
        tests++; if (n_imem_req !== 1) begin fails++; $display("FAIL addi_imem_req_count: got %0d expected 1", n_imem_req); end
        tests++; if (cap_iaddr !== RST_PC) begin fails++; $display("FAIL addi_imem_addr: got %h expected %h", cap_iaddr, RST_PC); end
        tests++; if (n_retire !== 1 || retire_cyc !== 4) begin fails++; $display("FAIL addi_retire: got count %0d cycle %0d expected 1 at 4", n_retire, retire_cyc); end
        tests++; if (n_rfwe !== 1 || rfwe_cyc !== 4) begin fails++; $display("FAIL addi_rf_we: got count %0d cycle %0d expected 1 at 4", n_rfwe, rfwe_cyc); end
        tests++; if (n_dmem_req !== 0) begin fails++; $display("FAIL addi_no_dmem: got %0d expected 0", n_dmem_req); end
        tests++; if (pc !== 32'h4) begin fails++; $display("FAIL addi_pc: got %h expected 00000004", pc); end
        tests++; if (instr !== 32'h0050_0093) begin fails++; $display("FAIL addi_instr: got %h expected 00500093", instr); end
    endtask

    task automatic test_load();
        run_instr(32'h1000_2083, 1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h55, 32'h8, 32'hDEAD_BEEF, 3, 16);
        tests++; if (cap_iaddr !== 32'h4) begin fails++; $display("FAIL load_imem_addr: got %h expected 00000004", cap_iaddr); end
        tests++; if (n_dmem_req !== 1) begin fails++; $display("FAIL load_dmem_req_count: got %0d expected 1", n_dmem_req); end
        tests++; if (cap_daddr !== 32'h100 || cap_we !== 1'b0) begin fails++; $display("FAIL load_dmem_addr_we: got %h/%b expected 00000100/0", cap_daddr, cap_we); end
        tests++; if (retire_cyc !== 7 || rfwe_cyc !== 7) begin fails++; $display("FAIL load_retire_cycle: got %0d/%0d expected 7/7", retire_cyc, rfwe_cyc); end
        tests++; if (ld_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_ld_data: got %h expected deadbeef", ld_data); end
        tests++; if (pc !== 32'h8) begin fails++; $display("FAIL load_pc: got %h expected 00000008", pc); end
    endtask

    task automatic test_store();
        run_instr(32'h0020_A023, 1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h1234, 32'hC, 32'hFFFF_FFFF, 1, 12);
        tests++; if (n_dmem_req !== 1 || cap_we !== 1'b1) begin fails++; $display("FAIL store_req_we: got %0d/%b expected 1/1", n_dmem_req, cap_we); end
        tests++; if (cap_daddr !== 32'h200 || cap_wdata !== 32'h1234) begin fails++; $display("FAIL store_addr_wdata: got %h/%h expected 00000200/00001234", cap_daddr, cap_wdata); end
        tests++; if (n_rfwe !== 0 || retire_cyc !== 5) begin fails++; $display("FAIL store_retire: got rf_we %0d retire cycle %0d expected 0 at 5", n_rfwe, retire_cyc); end
        tests++; if (ld_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_ld_data_kept: got %h expected deadbeef", ld_data); end
        tests++; if (pc !== 32'hC) begin fails++; $display("FAIL store_pc: got %h expected 0000000c", pc); end
    endtask

    // Store wins over load, and a fetch answered on the last allowed wait cycle succeeds.
    task automatic test_back_to_back();
        run_instr(32'h0000_0013, 4, 1'b1, 1'b1, 1'b1, 32'h300, 32'hA5A5_0000, 32'h10, 32'h5555_5555, 1, 16);
        tests++; if (bus_err !== 1'b0 || retire_cyc !== 8) begin fails++; $display("FAIL edge_wait_retire: got bus_err %b cycle %0d expected 0 at 8", bus_err, retire_cyc); end
        tests++; if (cap_we !== 1'b1 || cap_wdata !== 32'hA5A5_0000) begin fails++; $display("FAIL store_wins_we: got %b/%h expected 1/a5a50000", cap_we, cap_wdata); end
        tests++; if (ld_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_wins_ld_data: got %h expected deadbeef", ld_data); end
        tests++; if (pc !== 32'h10) begin fails++; $display("FAIL b2b_pc: got %h expected 00000010", pc); end
    endtask

    task automatic test_ebreak();
        run_instr(32'h0010_0073, 1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 32'h0, 1, 8);
        tests++; if (halted !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL ebreak_halted: got %b/%b expected 1/0", halted, bus_err); end
        tests++; if (n_retire !== 0 || n_rfwe !== 0) begin fails++; $display("FAIL ebreak_no_retire: got %0d/%0d expected 0/0", n_retire, n_rfwe); end
        tests++; if (pc !== 32'h10 || n_imem_req !== 1) begin fails++; $display("FAIL ebreak_pc_req: got %h/%0d expected 00000010/1", pc, n_imem_req); end
        tests++; if (instr !== 32'h0010_0073) begin fails++; $display("FAIL ebreak_instr: got %h expected 00100073", instr); end
    endtask

    task automatic test_timeout();
        do_reset();
        rst = 1'b0;
        run_instr(32'h0000_0013, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 32'h0, 1, 12);
        tests++; if (bus_err !== 1'b1 || err_cyc !== 6) begin fails++; $display("FAIL timeout_bus_err: got %b first cycle %0d expected 1 at 6", bus_err, err_cyc); end
        tests++; if (n_imem_req !== 1 || n_retire !== 0) begin fails++; $display("FAIL timeout_reqs: got %0d req %0d retire expected 1/0", n_imem_req, n_retire); end
        do_reset();
        rst = 1'b0;
        tests++; if (pc !== RST_PC || bus_err !== 1'b0) begin fails++; $display("FAIL timeout_recover: got %h/%b expected %h/0", pc, bus_err, RST_PC); end
    endtask

    task automatic test_misaligned();
        run_instr(32'h0000_0013, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, RST_PC + 32'h6, 32'h0, 1, 12);
        tests++; if (pc !== RST_PC + 32'h6) begin fails++; $display("FAIL misalign_pc_taken: got %h expected %h", pc, RST_PC + 32'h6); end
        run_instr(32'h0000_0013, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 6);
        tests++; if (n_imem_req !== 0) begin fails++; $display("FAIL misalign_no_req: got %0d expected 0", n_imem_req); end
        tests++; if (bus_err !== 1'b1 || err_cyc !== 2 || n_retire !== 0) begin fails++; $display("FAIL misalign_bus_err: got %b at %0d retire %0d expected 1 at 2, 0", bus_err, err_cyc, n_retire); end
    endtask

    task automatic test_reset_in_dwait();
        do_reset();
        rst = 1'b0;
        run_instr(32'h0000_0013, 1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200, 32'h0, 1, 12);
        run_instr(32'h1000_2083, 1, 1'b1, 1'b0, 1'b1, 32'h180, 32'h0, 32'h204, 32'h0, 0, 4);
        tests++; if (pc !== 32'h200 || n_dmem_req !== 1) begin fails++; $display("FAIL dwait_setup: got %h/%0d expected 00000200/1", pc, n_dmem_req); end
        rst = 1'b1;
        tick();
        tests++; if (pc !== RST_PC || rf_we !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL dwait_reset: got %h/%b/%b expected %h/0/0", pc, rf_we, dmem_req, RST_PC); end
        rst = 1'b0;
        ctl_mem_rd = 1'b0;
        dmem_rdata = 32'hBAD0_BAD0;
        dmem_rvalid = 1'b1;
        tick();
        tick();
        tests++; if (ld_data !== 32'h0 || retire !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL late_rvalid_ignored: got %h/%b/%b expected 0/0/0", ld_data, retire, dmem_req); end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_back_to_back();
        test_ebreak();
        test_timeout();
        test_misaligned();
        test_reset_in_dwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
